// File: rtl/hex_display_ctrl_if.sv
// CPU-side register bus of the hex display controller: write port, readback port and busy flag.
interface hex_display_ctrl_if;
  logic        wr_en;
  logic        wr_addr;
  logic [31:0] wr_data;
  logic        rd_addr;
  logic [31:0] rd_data;
  logic        busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr,
    input  rd_data, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr,
    output rd_data, busy
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Six-digit seven-segment controller with DATA/CTRL shadow registers copied to the display on refresh ticks.
// Define DISP_SYNC_BYPASS_EN to write the active registers directly (no tear-free transfer, busy held at 0).
module hex_display_ctrl #(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned BLINK_HALF = 250
) (
  input  logic                      clk,
  input  logic                      resetn,
  hex_display_ctrl_if.slave         bus,
  output logic [6:0]                hex0,
  output logic [6:0]                hex1,
  output logic [6:0]                hex2,
  output logic [6:0]                hex3,
  output logic [6:0]                hex4,
  output logic [6:0]                hex5
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  localparam logic [8:0] CTRL_RESET = 9'h03F;
  localparam logic [6:0] SEG_ZERO   = 7'h40;
  localparam logic [6:0] SEG_BLANK  = 7'h7F;

  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic          tick;

  logic [31:0]   data_sh;
  logic [8:0]    ctrl_sh;
  logic [31:0]   data_act;
  logic [8:0]    ctrl_act;
  logic          pending;

  logic [23:0]   window;
  logic          zero_run;
  logic [6:0]    seg_next [6];

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = (tick_cnt == TICK_LAST);

  // Refresh tick divider and blink half-period counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Shadow registers and readback
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_sh     <= '0;
      ctrl_sh     <= CTRL_RESET;
      bus.rd_data <= '0;
    end else begin
      if (bus.wr_en) begin
        if (bus.wr_addr) ctrl_sh <= bus.wr_data[8:0];
        else             data_sh <= bus.wr_data;
      end
      bus.rd_data <= bus.rd_addr ? {23'b0, ctrl_sh} : data_sh;
    end
  end

  // Active registers; the transfer uses pre-edge shadows, so a write on the
  // tick edge lands in the shadow and keeps pending set for the next tick.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_act <= '0;
      ctrl_act <= CTRL_RESET;
      pending  <= 1'b0;
    end else begin
`ifdef DISP_SYNC_BYPASS_EN
      pending <= 1'b0;
      if (bus.wr_en) begin
        if (bus.wr_addr) ctrl_act <= bus.wr_data[8:0];
        else             data_act <= bus.wr_data;
      end
`else
      if (tick && pending) begin
        data_act <= data_sh;
        ctrl_act <= ctrl_sh;
      end
      if (bus.wr_en)  pending <= 1'b1;
      else if (tick)  pending <= 1'b0;
`endif
    end
  end

  assign bus.busy = pending;

  // Digit decode, scanning from the most significant digit so zero_run
  // holds "this digit and every digit above it are zero".
  always_comb begin
    window   = ctrl_act[8] ? data_act[31:8] : data_act[23:0];
    zero_run = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      seg_next[k] = SEG_BLANK;
    end
    for (int unsigned k = 0; k < 6; k++) begin
      int unsigned i;
      logic [3:0]  nib;
      i        = 5 - k;
      nib      = window[4*i +: 4];
      zero_run = zero_run & (nib == 4'h0);
      if (!ctrl_act[i] || (ctrl_act[6] && blink_phase) ||
          (ctrl_act[7] && (i != 0) && zero_run))
        seg_next[i] = SEG_BLANK;
      else
        seg_next[i] = seg7(nib);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hex0 <= SEG_ZERO;
      hex1 <= SEG_ZERO;
      hex2 <= SEG_ZERO;
      hex3 <= SEG_ZERO;
      hex4 <= SEG_ZERO;
      hex5 <= SEG_ZERO;
    end else begin
      hex0 <= seg_next[0];
      hex1 <= seg_next[1];
      hex2 <= seg_next[2];
      hex3 <= seg_next[3];
      hex4 <= seg_next[4];
      hex5 <= seg_next[5];
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with TICK_DIV=4, BLINK_HALF=2.
module tb_hex_display_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

  int nchk = 0;
  int nerr = 0;

  hex_display_ctrl_if bus ();

  hex_display_ctrl #(.TICK_DIV(4), .BLINK_HALF(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave),
    .hex0   (hex0),
    .hex1   (hex1),
    .hex2   (hex2),
    .hex3   (hex3),
    .hex4   (hex4),
    .hex5   (hex5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    assert (act === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic addr, input logic [31:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    step();
    bus.wr_en   = 1'b0;
  endtask

  // Leaves the bench just after the transfer edge on which busy fell.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 12) begin
      step();
      n++;
    end
    check(tag, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [6:0] v;
    int n;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 1'b0;
    bus.wr_data = '0;
    bus.rd_addr = 1'b0;

    // Reset state
    #12;
    check("rst_hex0", hex0, 32'h40);
    check("rst_hex5", hex5, 32'h40);
    check("rst_busy", bus.busy, 32'd0);
    check("rst_rd", bus.rd_data, 32'd0);
    #1 resetn = 1'b1;
    step();
    bus.rd_addr = 1'b1;
    step();
    check("rd_ctrl_reset", bus.rd_data, 32'h3F);
    bus.rd_addr = 1'b0;

`ifdef DISP_SYNC_BYPASS_EN
    write(1'b0, 32'h00123456);
    check("byp_busy", bus.busy, 32'd0);
    step();
    check("byp_hex0", hex0, 32'h02);
    check("byp_hex5", hex5, 32'h79);
    write(1'b1, 32'h000000BF);
    write(1'b0, 32'h000000A0);
    check("byp_busy2", bus.busy, 32'd0);
    step();
    check("byp_zs_hex1", hex1, 32'h08);
    check("byp_zs_hex2", hex2, 32'h7F);
`else
    // DATA write, tear-free transfer on the tick
    write(1'b0, 32'h00123456);
    check("t2_busy", bus.busy, 32'd1);
    wait_idle("t2_idle");
    check("t2_hex5_old", hex5, 32'h40);
    step();
    check("t2_hex5", hex5, 32'h79);
    check("t2_hex4", hex4, 32'h24);
    check("t2_hex3", hex3, 32'h30);
    check("t2_hex2", hex2, 32'h19);
    check("t2_hex1", hex1, 32'h12);
    check("t2_hex0", hex0, 32'h02);

    // Leading-zero suppression
    write(1'b1, 32'h000000BF);
    write(1'b0, 32'h000000A0);
    wait_idle("t3_idle");
    step();
    check("t3_hex0", hex0, 32'h40);
    check("t3_hex1", hex1, 32'h08);
    check("t3_hex2", hex2, 32'h7F);
    check("t3_hex5", hex5, 32'h7F);

    // Blink: each half-period is 2 ticks = 8 clk cycles
    write(1'b1, 32'h0000007F);
    wait_idle("t4_idle");
    step();
    v = hex0;
    n = 0;
    while (hex0 === v && n < 12) begin
      step();
      n++;
    end
    check("t4_toggle_seen", {31'b0, (hex0 !== v)}, 32'd1);
    for (int h = 0; h < 2; h++) begin
      v = hex0;
      check("t4_blink_val", {31'b0, (v === 7'h40 || v === 7'h7F)}, 32'd1);
      check("t4_hex1_sync", hex1, (v === 7'h7F) ? 32'h7F : 32'h08);
      for (int c = 0; c < 7; c++) begin
        step();
        check("t4_hold", hex0, v);
      end
      step();
      check("t4_flip", hex0, (v === 7'h7F) ? 32'h40 : 32'h7F);
    end

    // Page select, CTRL readback masking, read-during-write returns old value
    write(1'b1, 32'hABCDE13F);
    bus.rd_addr = 1'b0;
    write(1'b0, 32'hFEDCBA98);
    check("t5_rd_old", bus.rd_data, 32'h000000A0);
    wait_idle("t5_idle");
    step();
    check("t5_hex5", hex5, 32'h0E);
    check("t5_hex4", hex4, 32'h06);
    check("t5_hex3", hex3, 32'h21);
    check("t5_hex2", hex2, 32'h46);
    check("t5_hex1", hex1, 32'h03);
    check("t5_hex0", hex0, 32'h08);
    bus.rd_addr = 1'b1;
    step();
    check("t5_rd_ctrl", bus.rd_data, 32'h0000013F);
    bus.rd_addr = 1'b0;
    step();
    check("t5_rd_data", bus.rd_data, 32'hFEDCBA98);

    // Write landing on a tick edge stays pending until the following tick
    write(1'b1, 32'h0000003F);
    wait_idle("t6_idle");
    step();
    write(1'b0, 32'h00111111);
    step();
    write(1'b0, 32'h00222222);
    check("t6_busy_kept", bus.busy, 32'd1);
    step();
    check("t6_hex0_first", hex0, 32'h79);
    check("t6_busy_still", bus.busy, 32'd1);
    step();
    step();
    step();
    check("t6_busy_clear", bus.busy, 32'd0);
    check("t6_hex0_pre", hex0, 32'h79);
    step();
    check("t6_hex0_second", hex0, 32'h24);

    // Reset while a write is pending discards it
    write(1'b0, 32'h00FFFFFF);
    check("t7_busy", bus.busy, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("t7_rst_hex0", hex0, 32'h40);
    check("t7_rst_busy", bus.busy, 32'd0);
    check("t7_rst_rd", bus.rd_data, 32'd0);
    #2 resetn = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check("t7_hex0_after", hex0, 32'h40);
    check("t7_hex5_after", hex5, 32'h40);
    check("t7_busy_after", bus.busy, 32'd0);
    bus.rd_addr = 1'b1;
    step();
    check("t7_rd_ctrl", bus.rd_data, 32'h3F);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
